// File: rtl/mul_div_unit_divider_if.sv
// mul_div_unit_divider_if: start/operand request and result bus of the iterative divider
interface mul_div_unit_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             dz;
  modport master (output start, sgn, a, b, input busy, done, lo, hi, dz);
  modport slave (input start, sgn, a, b, output busy, done, lo, hi, dz);
endinterface

// File: rtl/mul_div_unit_divider.sv
// mul_div_unit_divider: multi-cycle restoring DIV/DIVU, quotient to lo and remainder to hi
module mul_div_unit_divider #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  mul_div_unit_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state, next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs, lo, hi, diff;
  logic [WIDTH:0]   sh;
  logic             neg_q, neg_r, dz, ge;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.lo   = lo;
  assign bus.hi   = hi;
  assign bus.dz   = dz;
  // one restoring step: shifted partial remainder compared against the divisor magnitude
  always_comb begin
    sh   = {rem, quo[WIDTH-1]};
    ge   = sh >= {1'b0, dvs};
    diff = sh[WIDTH-1:0] - dvs;
  end
  // next state: divide-by-zero skips straight to DONE, CALC runs WIDTH steps
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = bus.start ? ((bus.b == '0) ? DONE : CALC) : IDLE;
      CALC:    next = (cnt == CW'(1)) ? FIX : CALC;
      FIX:     next = DONE;
      default: next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next;
  // datapath: operand capture, iteration, sign fix-up and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      lo    <= '0;
      hi    <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          if (bus.b == '0) begin
            lo <= '1;
            hi <= bus.a;
            dz <= 1'b1;
          end else begin
            quo   <= (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
            dvs   <= (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
            rem   <= '0;
            cnt   <= CW'(WIDTH);
            neg_q <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r <= bus.sgn & bus.a[WIDTH-1];
          end
        end
        CALC: begin
          rem <= ge ? diff : sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          lo <= neg_q ? -quo : quo;
          hi <= neg_r ? -rem : rem;
          dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit_divider.sv
// tb_mul_div_unit_divider: directed vectors checked against a cycle-level arithmetic model
module tb_mul_div_unit_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass = 0;
  mul_div_unit_divider_if #(.WIDTH(32)) bus ();
  mul_div_unit_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask
  // result from arithmetic rules: {dz, hi, lo}
  function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
    if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {1'b0, 32'(r), 32'(q)};
    end
    return {1'b0, a % b, a / b};
  endfunction
  int          m_cnt = 0;
  logic [64:0] m_pend = '0;
  logic [31:0] m_lo = '0, m_hi = '0;
  logic        m_dz = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_lo  <= '0;
      m_hi  <= '0;
      m_dz  <= 1'b0;
    end else if (m_cnt == 0) begin
      if (bus.start) begin
        m_pend <= model(bus.sgn, bus.a, bus.b);
        m_cnt  <= (bus.b == 0) ? 1 : 34;
        if (bus.b == 0) {m_dz, m_hi, m_lo} <= model(bus.sgn, bus.a, bus.b);
      end
    end else begin
      if (m_cnt == 2) {m_dz, m_hi, m_lo} <= m_pend;
      m_cnt <= m_cnt - 1;
    end
  end
  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(m_cnt != 0));
    chk("done", 64'(bus.done), 64'(m_cnt == 1));
    chk("lo", 64'(bus.lo), 64'(m_lo));
    chk("hi", 64'(bus.hi), 64'(m_hi));
    chk("dz", 64'(bus.dz), 64'(m_dz));
  end
  task automatic run(input string nm, input logic s, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] elo, input logic [31:0] ehi, input logic edz, input int elat);
    int n;
    bus.sgn = s;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(elat));
    chk({nm, "_lo"}, 64'(bus.lo), 64'(elo));
    chk({nm, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({nm, "_dz"}, 64'(bus.dz), 64'(edz));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    bus.start = 1'b0;
    bus.sgn = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out", {31'(bus.done), bus.dz, bus.lo}, 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    run("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
    run("divu_m100_7", 1'b0, 32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0, 34);
    run("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34);
    run("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
    run("dz", 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1);
    bus.sgn = 1'b0;
    bus.a = 32'd50;
    bus.b = 32'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      bus.start = (n == 10);
      if (n == 10) begin
        bus.a = 32'd9;
        bus.b = 32'd3;
      end
      @(posedge clk);
      #1 n++;
    end
    bus.start = 1'b0;
    chk("ign_lat", 64'(n), 64'd34);
    chk("ign_res", {bus.hi, bus.lo}, {32'd0, 32'd10});
    chk("ign_dz", 64'(bus.dz), 64'd0);
    @(posedge clk);
    #1;
    run("b2b_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 34);
    bus.sgn = 1'b0;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_res", {bus.hi, bus.lo}, 64'd0);
    chk("arst_dz", 64'(bus.dz), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run("divu_13_4", 1'b0, 32'd13, 32'd4, 32'd3, 32'd1, 1'b0, 34);
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
